// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset datapath.
// Splits each instruction into FETCH / DECODE / EXEC / WB steps. It drives the
// datapath enables and selects, handshakes with instruction memory and counts
// retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [5:0]       instr_op_i,
    input  logic [5:0]       funct_i,
    input  logic             alu_zero_i,
    input  logic             imem_ack_i,
    output logic             imem_req_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic             reg_dst_o,
    output logic             reg_write_o,
    output logic             illegal_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC_R = 3'd2,
        S_EXEC_I = 3'd3,
        S_BRANCH = 3'd4,
        S_WB_R   = 3'd5,
        S_WB_I   = 3'd6
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] FN_SRA  = 6'b000011;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             retire;

    // IR is stable from DECODE until the next fetch, so decode it directly.
    logic is_r, is_addi, is_slti, is_beq, is_bne, is_sra;
    assign is_r    = (instr_op_i == OP_R);
    assign is_addi = (instr_op_i == OP_ADDI);
    assign is_slti = (instr_op_i == OP_SLTI);
    assign is_beq  = (instr_op_i == OP_BEQ);
    assign is_bne  = (instr_op_i == OP_BNE);
    assign is_sra  = (funct_i == FN_SRA);

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_reg <= '0;
        end else if (retire) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Next-state and control decode; all outputs forced low while reset is held.
    always_comb begin
        state_next  = state_reg;
        retire      = 1'b0;
        imem_req_o  = 1'b0;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = 1'b0;
        alu_src_a_o = 2'b00;
        alu_src_b_o = 2'b00;
        alu_op_o    = 3'b000;
        reg_dst_o   = 1'b0;
        reg_write_o = 1'b0;
        illegal_o   = 1'b0;

        case (state_reg)
            S_FETCH: begin
                imem_req_o = run_i;
                if (run_i && imem_ack_i) begin
                    // PC <= PC + 4 while the IR loads.
                    ir_write_o  = 1'b1;
                    pc_write_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    state_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target PC + (imm<<2) is computed here into ALUOut.
                alu_src_b_o = 2'b11;
                if (is_r) begin
                    state_next = S_EXEC_R;
                end else if (is_addi || is_slti) begin
                    state_next = S_EXEC_I;
                end else if (is_beq || is_bne) begin
                    state_next = S_BRANCH;
                end else begin
                    illegal_o  = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXEC_R, S_WB_R: begin
                alu_src_a_o = is_sra ? 2'b10 : 2'b01;
                alu_op_o    = 3'b010;
                if (state_reg == S_WB_R) begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 1'b1;
                    retire      = 1'b1;
                    state_next  = S_FETCH;
                end else begin
                    state_next  = S_WB_R;
                end
            end
            S_EXEC_I, S_WB_I: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                alu_op_o    = is_slti ? 3'b011 : 3'b000;
                if (state_reg == S_WB_I) begin
                    reg_write_o = 1'b1;
                    retire      = 1'b1;
                    state_next  = S_FETCH;
                end else begin
                    state_next  = S_WB_I;
                end
            end
            S_BRANCH: begin
                // rs - rt sets the zero flag; the decision is taken the same cycle.
                alu_src_a_o = 2'b01;
                alu_op_o    = 3'b001;
                pc_src_o    = 1'b1;
                pc_write_o  = is_bne ? ~alu_zero_i : alu_zero_i;
                retire      = 1'b1;
                state_next  = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        if (!rst_i) begin
            imem_req_o  = 1'b0;
            ir_write_o  = 1'b0;
            pc_write_o  = 1'b0;
            pc_src_o    = 1'b0;
            alu_src_a_o = 2'b00;
            alu_src_b_o = 2'b00;
            alu_op_o    = 3'b000;
            reg_dst_o   = 1'b0;
            reg_write_o = 1'b0;
            illegal_o   = 1'b0;
        end
    end

    assign state_o     = state_reg;
    assign instr_cnt_o = cnt_reg;

endmodule
